// File: rtl/nn_dtypes_pkg.sv
// Shared NN datapath types: FP32/BF16 field layouts, BF16 special constants and conversion flags.
package nn_dtypes_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } fp32_t;

    typedef struct packed {
        logic       sign;
        logic [7:0] exponent;
        logic [6:0] mantissa;
    } bf16_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inexact;
    } cvt_flags_t;

    typedef struct packed {
        bf16_t      data;
        cvt_flags_t flags;
    } cvt_result_t;

    localparam bf16_t BF16_QNAN    = 16'h7FC0;
    localparam bf16_t BF16_POS_INF = 16'h7F80;
    localparam bf16_t BF16_NEG_INF = 16'hFF80;

endpackage

// File: rtl/nn_sync_fifo.sv
// Synchronous-reset FIFO for stream stages; a push into a full FIFO is taken when a pop happens on the same edge.
module nn_sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    // Storage is not reset, so the head is masked to keep the read port at zero while empty.
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fp32_bf16_downconv.sv
// FP32 -> BF16 down-converter with status-flag merge, one stage register and a small output FIFO.
// Define FP32_BF16_STOCH_ROUND_EN to replace round-to-nearest-even with LFSR-driven stochastic rounding.
module fp32_bf16_downconv
    import nn_dtypes_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_ovf,
    input  logic        in_unf,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [2:0]  out_flags,
    output logic        drop_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = $bits(cvt_result_t);

    // An all-zero seed would lock the LFSR permanently.
    if (LFSR_SEED == 16'h0) begin : g_seed_check
        $error("LFSR_SEED must be nonzero");
    end

    function automatic cvt_result_t convert(input fp32_t d, input logic up_ovf,
                                            input logic up_unf, input logic round_up);
        cvt_result_t r;
        logic [14:0] mag;
        r   = '0;
        mag = '0;
        if (d.exponent == 8'hFF && d.mantissa != '0) begin
            r.data      = BF16_QNAN;
            r.data.sign = d.sign;
        end else if (d.exponent == 8'hFF) begin
            r.data      = d[31:16];
            r.flags.ovf = up_ovf;
        end else if (d.exponent == 8'h00) begin
            r.data.sign     = d.sign;
            r.flags.unf     = (d.mantissa != '0) | up_unf;
            r.flags.inexact = (d.mantissa != '0);
        end else begin
            // A carry out of the mantissa lands in the exponent; reaching FF means the value became Inf.
            mag             = d[30:16] + 15'(round_up);
            r.data          = {d.sign, mag};
            r.flags.ovf     = (mag[14:7] == 8'hFF) | up_ovf;
            r.flags.unf     = up_unf;
            r.flags.inexact = |d[15:0];
        end
        return r;
    endfunction

    logic              accept;
    logic              round_up;
    cvt_result_t       cvt;
    logic              s1_valid;
    cvt_result_t       s1_q;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [RW-1:0]     fifo_rd;

    assign in_ready = ~fifo_full & ((fifo_count + CW'(s1_valid)) < CW'(DEPTH));
    assign accept   = in_valid & in_ready;

`ifdef FP32_BF16_STOCH_ROUND_EN
    logic [15:0] lfsr;

    assign round_up = (17'(in_data[15:0]) + 17'(lfsr)) >= 17'h10000;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else if (accept)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
`else
    assign round_up = in_data[15] & ((|in_data[14:0]) | in_data[16]);
`endif

    assign cvt = convert(fp32_t'(in_data), in_ovf, in_unf, round_up);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept)
                s1_q <= cvt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            drop_err <= 1'b0;
        else if (in_valid && !in_ready)
            drop_err <= 1'b1;
    end

    nn_sync_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (s1_valid),
        .wr_data (s1_q),
        .pop     (out_valid & out_ready),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_valid             = ~fifo_empty;
    assign {out_data, out_flags} = fifo_rd;

endmodule
